// File: rtl/reg_bus_arbiter_if.sv
// Requester-side and register-bus-side signals of the two-requester register bus arbiter.
// slave: the arbiter's view; master: the requesters plus register block (environment) view.
interface reg_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                  m_req;
  logic [1:0]                  m_is_wr;
  logic [2*ADDR_WIDTH-1:0]     m_addr;
  logic [2*DATA_WIDTH-1:0]     m_wr_data;
  logic [2*DATA_WIDTH/8-1:0]   m_wr_biten;
  logic [1:0]                  m_ack;
  logic                        m_err;
  logic [DATA_WIDTH-1:0]       m_rd_data;

  logic                        bus_req;
  logic                        bus_req_is_wr;
  logic [ADDR_WIDTH-1:0]       bus_addr;
  logic [DATA_WIDTH-1:0]       bus_wr_data;
  logic [DATA_WIDTH/8-1:0]     bus_wr_biten;
  logic                        bus_ready;
  logic                        bus_err;
  logic [DATA_WIDTH-1:0]       bus_rd_data;

  // Handshake: m_req[i] is a level held until the one-cycle m_ack[i] pulse; bus_req is a
  // one-cycle pulse and bus_ready|bus_err completes it (same cycle or later), with bus_*
  // fields stable throughout. m_err/m_rd_data are meaningful only while m_ack is nonzero.
  modport slave (
    input  m_req, m_is_wr, m_addr, m_wr_data, m_wr_biten,
    output m_ack, m_err, m_rd_data,
    output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    input  bus_ready, bus_err, bus_rd_data
  );

  modport master (
    output m_req, m_is_wr, m_addr, m_wr_data, m_wr_biten,
    input  m_ack, m_err, m_rd_data,
    input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
    output bus_ready, bus_err, bus_rd_data
  );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter muxing two requesters onto one register bus (IDLE -> ACTIVE -> RESP).
// Optional watchdog on the ACTIVE state enabled by the REG_ARB_TIMEOUT_EN macro.
module reg_bus_arbiter #(
  parameter int ADDR_WIDTH     = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_bus_arbiter_if.slave  bif,
  output logic              busy,
  output logic              grant_idx,
  output logic [1:0]        state_dbg
);
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2} state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_t                state_q, state_d;
  logic                  grant_q;
  logic                  bus_req_q;
  logic                  is_wr_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [SW-1:0]         biten_q;
  logic [1:0]            ack_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic win;
  logic grant;
  logic done;
  logic timeout;
  logic finish;

  // A lone requester always wins; with both asking, the one not served last goes next.
  always_comb begin
    win = ~grant_q;
    if (bif.m_req == 2'b01)      win = 1'b0;
    else if (bif.m_req == 2'b10) win = 1'b1;
  end

  assign grant  = (state_q == IDLE) && (|bif.m_req);
  assign done   = (state_q == ACTIVE) && (bif.bus_ready || bif.bus_err);
  assign finish = (state_q == ACTIVE) && (done || timeout);

`ifdef REG_ARB_TIMEOUT_EN
  logic [7:0] cnt_q;

  // cnt_q counts completed ACTIVE cycles without a response.
  assign timeout = (state_q == ACTIVE) && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             cnt_q <= 8'd0;
    else if (grant)                         cnt_q <= 8'd0;
    else if (state_q == ACTIVE && !done)    cnt_q <= cnt_q + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant)  state_d = ACTIVE;
      ACTIVE:  if (finish) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b1;
      bus_req_q <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      biten_q   <= '0;
      ack_q     <= 2'b00;
      err_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bus_req_q <= grant;
      ack_q     <= 2'b00;
      if (grant) begin
        grant_q   <= win;
        is_wr_q   <= bif.m_is_wr[win];
        addr_q    <= win ? bif.m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bif.m_addr[ADDR_WIDTH-1:0];
        wr_data_q <= win ? bif.m_wr_data[2*DATA_WIDTH-1:DATA_WIDTH]
                         : bif.m_wr_data[DATA_WIDTH-1:0];
        biten_q   <= win ? bif.m_wr_biten[2*SW-1:SW] : bif.m_wr_biten[SW-1:0];
      end
      // A real response takes precedence over a watchdog expiry in the same cycle.
      if (finish) begin
        ack_q[grant_q] <= 1'b1;
        err_q          <= done ? bif.bus_err : 1'b1;
        rd_data_q      <= (done && !is_wr_q) ? bif.bus_rd_data : '0;
      end else if (state_q == RESP) begin
        err_q     <= 1'b0;
        rd_data_q <= '0;
      end
    end
  end

  assign bif.m_ack         = ack_q;
  assign bif.m_err         = err_q;
  assign bif.m_rd_data     = rd_data_q;
  assign bif.bus_req       = bus_req_q;
  assign bif.bus_req_is_wr = is_wr_q;
  assign bif.bus_addr      = addr_q;
  assign bif.bus_wr_data   = wr_data_q;
  assign bif.bus_wr_biten  = biten_q;

  assign busy      = (state_q != IDLE);
  assign grant_idx = grant_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: reset, single read, round-robin, write error,
// watchdog / indefinite wait, and reset during ACTIVE.
module tb_reg_bus_arbiter;
  localparam int AW = 3;
  localparam int DW = 32;
`ifdef REG_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       grant_idx;
  logic [1:0] state_dbg;

  int checks;
  int errors;

  reg_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  reg_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bif       (bif),
    .busy      (busy),
    .grant_idx (grant_idx),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bif.m_req       = 2'b00;
    bif.m_is_wr     = 2'b00;
    bif.m_addr      = '0;
    bif.m_wr_data   = '0;
    bif.m_wr_biten  = '0;
    bif.bus_ready   = 1'b0;
    bif.bus_err     = 1'b0;
    bif.bus_rd_data = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    step();
    step();
    checks++;
    if (bif.m_ack !== 2'b00 || busy !== 1'b0 || grant_idx !== 1'b1 || bif.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ack=%b busy=%b grant=%b bus_req=%b want 00/0/1/0",
               bif.m_ack, busy, grant_idx, bif.bus_req);
    end
    checks++;
    if (bif.m_rd_data !== '0 || bif.m_err !== 1'b0 || bif.bus_addr !== '0 ||
        bif.bus_wr_data !== '0 || bif.bus_wr_biten !== '0 || bif.bus_req_is_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_data rd=%h err=%b addr=%h wd=%h be=%h wr=%b want all 0",
               bif.m_rd_data, bif.m_err, bif.bus_addr, bif.bus_wr_data,
               bif.bus_wr_biten, bif.bus_req_is_wr);
    end
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    bif.m_req              = 2'b01;
    bif.m_is_wr            = 2'b00;
    bif.m_addr[AW-1:0]     = 3'd3;
    bif.bus_ready          = 1'b1;
    bif.bus_rd_data        = 32'hDEADBEEF;
    step();  // grant edge
    checks++;
    if (bif.bus_req !== 1'b1 || bif.bus_addr !== 3'd3 || bif.bus_req_is_wr !== 1'b0 ||
        grant_idx !== 1'b0 || busy !== 1'b1 || bif.m_ack !== 2'b00) begin
      errors++;
      $display("FAIL rd_grant bus_req=%b addr=%0d wr=%b grant=%b busy=%b ack=%b want 1/3/0/0/1/00",
               bif.bus_req, bif.bus_addr, bif.bus_req_is_wr, grant_idx, busy, bif.m_ack);
    end
    step();
    checks++;
    if (bif.m_ack !== 2'b01 || bif.m_rd_data !== 32'hDEADBEEF || bif.m_err !== 1'b0 ||
        bif.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL rd_ack ack=%b rd=%h err=%b bus_req=%b want 01/deadbeef/0/0",
               bif.m_ack, bif.m_rd_data, bif.m_err, bif.bus_req);
    end
    drive_idle();
    step();
    checks++;
    if (bif.m_ack !== 2'b00 || bif.m_rd_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_after ack=%b rd=%h busy=%b want 00/0/0", bif.m_ack, bif.m_rd_data, busy);
    end
  endtask

  task automatic test_round_robin();
    logic exp_q[$];
    int   grant_cyc[$];
    logic exp_g;
    int   acks;
    int   grants;
    exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    acks   = 0;
    grants = 0;
    rst_n = 1'b0;
    #2;
    bif.m_req       = 2'b11;
    bif.bus_ready   = 1'b1;
    bif.bus_rd_data = 32'h0000_1111;
    step();
    #2 rst_n = 1'b1;
    for (int cyc = 0; cyc < 40 && acks < 4; cyc++) begin
      step();
      if (bif.bus_req === 1'b1) begin
        grant_cyc.push_back(cyc);
        exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        grants++;
        checks++;
        if (grant_idx !== exp_g) begin
          errors++;
          $display("FAIL rr_order grant#%0d got=%b want=%b", grants, grant_idx, exp_g);
        end
      end
      if (bif.m_ack !== 2'b00) begin
        acks++;
        checks++;
        if (bif.m_ack !== (grant_idx ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL rr_ack ack=%b grant=%b want one-hot of grant", bif.m_ack, grant_idx);
        end
      end
    end
    checks++;
    if (acks != 4 || grants != 4) begin
      errors++;
      $display("FAIL rr_count acks=%0d grants=%0d want 4/4", acks, grants);
    end
    for (int i = 1; i < grant_cyc.size(); i++) begin
      checks++;
      if (grant_cyc[i] - grant_cyc[i-1] != 3) begin
        errors++;
        $display("FAIL rr_spacing gap=%0d want 3", grant_cyc[i] - grant_cyc[i-1]);
      end
    end
    drive_idle();
    step();
    step();
  endtask

  task automatic test_write_err();
    bif.m_req                  = 2'b10;
    bif.m_is_wr                = 2'b10;
    bif.m_addr[2*AW-1:AW]      = 3'd5;
    bif.m_wr_data[2*DW-1:DW]   = 32'h12345678;
    bif.m_wr_biten[7:4]        = 4'hF;
    step();  // grant edge
    checks++;
    if (bif.bus_req !== 1'b1 || bif.bus_req_is_wr !== 1'b1 || bif.bus_addr !== 3'd5 ||
        bif.bus_wr_data !== 32'h12345678 || bif.bus_wr_biten !== 4'hF || grant_idx !== 1'b1) begin
      errors++;
      $display("FAIL wr_grant req=%b wr=%b addr=%0d wd=%h be=%h grant=%b want 1/1/5/12345678/f/1",
               bif.bus_req, bif.bus_req_is_wr, bif.bus_addr, bif.bus_wr_data,
               bif.bus_wr_biten, grant_idx);
    end
    bif.m_wr_data[2*DW-1:DW] = 32'hCAFEF00D;
    bif.m_addr[2*AW-1:AW]    = 3'd1;
    step();
    checks++;
    if (bif.bus_wr_data !== 32'h12345678 || bif.bus_addr !== 3'd5 || bif.m_ack !== 2'b00 ||
        busy !== 1'b1 || bif.bus_req !== 1'b0) begin
      errors++;
      $display("FAIL wr_hold wd=%h addr=%0d ack=%b busy=%b bus_req=%b want 12345678/5/00/1/0",
               bif.bus_wr_data, bif.bus_addr, bif.m_ack, busy, bif.bus_req);
    end
    bif.bus_ready   = 1'b1;
    bif.bus_err     = 1'b1;
    bif.bus_rd_data = 32'hFFFF0000;
    step();
    checks++;
    if (bif.m_ack !== 2'b10 || bif.m_err !== 1'b1 || bif.m_rd_data !== '0 ||
        bif.bus_wr_data !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_ack ack=%b err=%b rd=%h wd=%h want 10/1/0/12345678",
               bif.m_ack, bif.m_err, bif.m_rd_data, bif.bus_wr_data);
    end
    drive_idle();
    step();
    checks++;
    if (bif.m_ack !== 2'b00 || bif.m_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_after ack=%b err=%b busy=%b want 00/0/0", bif.m_ack, bif.m_err, busy);
    end
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    bif.m_req          = 2'b01;
    bif.m_addr[AW-1:0] = 3'd2;
    bif.bus_rd_data    = 32'h55AA55AA;
    step();  // grant edge, first ACTIVE cycle begins
`ifdef REG_ARB_TIMEOUT_EN
    for (int i = 1; i < 4; i++) begin
      step();
      if (bif.m_ack !== 2'b00 || busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL to_early cycles_with_ack_or_idle=%0d want 0", early);
    end
    step();
    checks++;
    if (bif.m_ack !== 2'b01 || bif.m_err !== 1'b1 || bif.m_rd_data !== '0) begin
      errors++;
      $display("FAIL to_ack ack=%b err=%b rd=%h want 01/1/0", bif.m_ack, bif.m_err, bif.m_rd_data);
    end
`else
    for (int i = 0; i < 100; i++) begin
      step();
      if (bif.m_ack !== 2'b00 || busy !== 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL wait_busy cycles_with_ack_or_idle=%0d want 0", early);
    end
    bif.bus_ready = 1'b1;
    step();
    checks++;
    if (bif.m_ack !== 2'b01 || bif.m_err !== 1'b0 || bif.m_rd_data !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL wait_ack ack=%b err=%b rd=%h want 01/0/55aa55aa",
               bif.m_ack, bif.m_err, bif.m_rd_data);
    end
`endif
    drive_idle();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    bif.m_req             = 2'b10;
    bif.m_addr[2*AW-1:AW] = 3'd7;
    step();  // grant edge
    step();  // second ACTIVE cycle
    checks++;
    if (state_dbg !== 2'd1 || grant_idx !== 1'b1) begin
      errors++;
      $display("FAIL rm_active state=%0d grant=%b want 1/1", state_dbg, grant_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bif.m_ack !== 2'b00 || busy !== 1'b0 || grant_idx !== 1'b1 || bif.bus_addr !== '0 ||
        bif.bus_req !== 1'b0 || bif.m_err !== 1'b0 || bif.m_rd_data !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL rm_reset ack=%b busy=%b grant=%b addr=%0d req=%b err=%b rd=%h st=%0d want 00/0/1/0/0/0/0/0",
               bif.m_ack, busy, grant_idx, bif.bus_addr, bif.bus_req, bif.m_err,
               bif.m_rd_data, state_dbg);
    end
    drive_idle();
    bif.bus_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bif.m_ack !== 2'b00) stray++;
    end
    rst_n = 1'b1;
    step();
    if (bif.m_ack !== 2'b00) stray++;
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rm_no_ack stray_acks=%0d want 0", stray);
    end
    bif.m_req          = 2'b01;
    bif.m_addr[AW-1:0] = 3'd4;
    bif.bus_rd_data    = 32'hA5A5A5A5;
    step();
    checks++;
    if (bif.bus_req !== 1'b1 || bif.bus_addr !== 3'd4 || grant_idx !== 1'b0) begin
      errors++;
      $display("FAIL rm_regrant req=%b addr=%0d grant=%b want 1/4/0",
               bif.bus_req, bif.bus_addr, grant_idx);
    end
    step();
    checks++;
    if (bif.m_ack !== 2'b01 || bif.m_rd_data !== 32'hA5A5A5A5 || bif.m_err !== 1'b0) begin
      errors++;
      $display("FAIL rm_ack ack=%b rd=%h err=%b want 01/a5a5a5a5/0",
               bif.m_ack, bif.m_rd_data, bif.m_err);
    end
    drive_idle();
    step();
  endtask

  // run + final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
